// File: rtl/line_render_scheduler.sv
// Per-scanline sequencer: detects line boundaries, runs PREP then DRAW, muxes the OAM read port,
// strobes the line-buffer swap and counts overruns. Optional stage watchdog: LINE_SCHED_WATCHDOG_EN.
module line_render_scheduler #(
  parameter int CORDW           = 10,
  parameter int V_RES           = 480,
  parameter int V_TOTAL         = 525,
  parameter int OAM_ADDR_W      = 6,
  parameter int WATCHDOG_CYCLES = 700
) (
  input  logic                  clk_pix,
  input  logic                  btn_rst,
  input  logic [CORDW-1:0]      sy,
  output logic                  prep_start,
  input  logic                  prep_done,
  output logic                  draw_start,
  input  logic                  draw_done,
  output logic                  stage_abort,
  input  logic [OAM_ADDR_W-1:0] oam_addr_prep,
  input  logic [OAM_ADDR_W-1:0] oam_addr_draw,
  output logic [OAM_ADDR_W-1:0] oam_read_addr,
  output logic [CORDW-1:0]      render_line,
  output logic                  buffer_swap,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           overrun_count
);

  typedef enum logic [1:0] {IDLE, PREP, DRAW, DONE} state_t;

  state_t           state_q;
  logic [CORDW-1:0] last_sy_q, render_line_q;
  logic             primed_q;
  logic             prep_start_q, draw_start_q, stage_abort_q, buffer_swap_q, overrun_q;
  logic [15:0]      ovr_cnt_q, ovr_cnt_d;

  logic             line_edge;
  logic [CORDW-1:0] tgt;
  logic             tgt_visible;

  // primed_q masks the first cycle after reset, when last_sy_q does not yet hold a real line
  assign line_edge   = primed_q && (sy != last_sy_q);
  assign tgt         = (sy == CORDW'(V_TOTAL-1)) ? '0 : sy + CORDW'(1);
  assign tgt_visible = (tgt < CORDW'(V_RES));
  assign ovr_cnt_d   = (ovr_cnt_q == 16'hFFFF) ? ovr_cnt_q : ovr_cnt_q + 16'd1;

`ifdef LINE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_trip;
  assign wd_trip = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));
  assign wd_d    = wd_q + WD_W'(1);
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = (WATCHDOG_CYCLES != 0);
`endif

  always_ff @(posedge clk_pix or negedge btn_rst) begin
    if (!btn_rst) begin
      state_q       <= IDLE;
      last_sy_q     <= '0;
      primed_q      <= 1'b0;
      render_line_q <= '0;
      prep_start_q  <= 1'b0;
      draw_start_q  <= 1'b0;
      stage_abort_q <= 1'b0;
      buffer_swap_q <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= '0;
`ifdef LINE_SCHED_WATCHDOG_EN
      wd_q          <= '0;
`endif
    end else begin
      last_sy_q     <= sy;
      primed_q      <= 1'b1;
      prep_start_q  <= 1'b0;
      draw_start_q  <= 1'b0;
      stage_abort_q <= 1'b0;
      buffer_swap_q <= 1'b0;
      overrun_q     <= 1'b0;
      if (line_edge) begin
        // a boundary always wins over a coincident done: the late stage is cut off
        render_line_q <= tgt;
        case (state_q)
          DONE: buffer_swap_q <= 1'b1;
          PREP, DRAW: begin
            stage_abort_q <= 1'b1;
            overrun_q     <= 1'b1;
            ovr_cnt_q     <= ovr_cnt_d;
          end
          default: ;
        endcase
        if (tgt_visible) begin
          prep_start_q <= 1'b1;
          state_q      <= PREP;
        end else begin
          state_q      <= IDLE;
        end
`ifdef LINE_SCHED_WATCHDOG_EN
        wd_q <= '0;
`endif
      end else begin
        case (state_q)
          PREP: begin
            if (prep_done) begin
              draw_start_q <= 1'b1;
              state_q      <= DRAW;
`ifdef LINE_SCHED_WATCHDOG_EN
              wd_q         <= '0;
            end else if (wd_trip) begin
              stage_abort_q <= 1'b1;
              overrun_q     <= 1'b1;
              ovr_cnt_q     <= ovr_cnt_d;
              state_q       <= IDLE;
            end else begin
              wd_q <= wd_d;
`endif
            end
          end
          DRAW: begin
            if (draw_done) begin
              state_q <= DONE;
`ifdef LINE_SCHED_WATCHDOG_EN
            end else if (wd_trip) begin
              stage_abort_q <= 1'b1;
              overrun_q     <= 1'b1;
              ovr_cnt_q     <= ovr_cnt_d;
              state_q       <= IDLE;
            end else begin
              wd_q <= wd_d;
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    oam_read_addr = '0;
    case (state_q)
      PREP:    oam_read_addr = oam_addr_prep;
      DRAW:    oam_read_addr = oam_addr_draw;
      default: oam_read_addr = '0;
    endcase
  end

  assign busy          = (state_q == PREP) || (state_q == DRAW);
  assign prep_start    = prep_start_q;
  assign draw_start    = draw_start_q;
  assign stage_abort   = stage_abort_q;
  assign buffer_swap   = buffer_swap_q;
  assign overrun       = overrun_q;
  assign overrun_count = ovr_cnt_q;
  assign render_line   = render_line_q;

endmodule

// File: tb/tb_line_render_scheduler.sv
// Directed bench for line_render_scheduler: a line-level model checked every cycle plus literal pins.
module tb_line_render_scheduler;
  localparam int CORDW = 10, V_RES = 480, V_TOTAL = 525, OAM_ADDR_W = 6, WATCHDOG_CYCLES = 700;
  localparam int M_IDLE = 0, M_PREP = 1, M_DRAW = 2, M_DONE = 3;

  logic                  clk_pix = 1'b0;
  logic                  btn_rst;
  logic [CORDW-1:0]      sy;
  logic                  prep_done, draw_done;
  logic [OAM_ADDR_W-1:0] oam_addr_prep, oam_addr_draw;
  logic                  prep_start, draw_start, stage_abort, buffer_swap, busy, overrun;
  logic [OAM_ADDR_W-1:0] oam_read_addr;
  logic [CORDW-1:0]      render_line;
  logic [15:0]           overrun_count;

  int checks = 0;
  int failures = 0;

  line_render_scheduler #(.CORDW(CORDW), .V_RES(V_RES), .V_TOTAL(V_TOTAL),
    .OAM_ADDR_W(OAM_ADDR_W), .WATCHDOG_CYCLES(WATCHDOG_CYCLES)) dut (
    .clk_pix(clk_pix), .btn_rst(btn_rst), .sy(sy),
    .prep_start(prep_start), .prep_done(prep_done),
    .draw_start(draw_start), .draw_done(draw_done),
    .stage_abort(stage_abort),
    .oam_addr_prep(oam_addr_prep), .oam_addr_draw(oam_addr_draw),
    .oam_read_addr(oam_read_addr), .render_line(render_line),
    .buffer_swap(buffer_swap), .busy(busy), .overrun(overrun),
    .overrun_count(overrun_count));

  always #5 clk_pix = ~clk_pix;

  // Line-level model: which phase of the line we are in and what the next cycle must show.
  typedef struct {
    int stage; int last_sy; bit primed; int render; int count;
    bit ps; bit ds; bit ab; bit sw; bit ov; int cyc; int entry;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.stage = M_IDLE; r.last_sy = 0; r.primed = 0; r.render = 0; r.count = 0;
    r.ps = 0; r.ds = 0; r.ab = 0; r.sw = 0; r.ov = 0; r.cyc = 0; r.entry = 0;
    return r;
  endfunction

  function automatic model_t step(model_t c, int s, bit pd, bit dd);
    model_t n;
    int t;
    n = c;
    n.ps = 0; n.ds = 0; n.ab = 0; n.sw = 0; n.ov = 0;
    n.cyc = c.cyc + 1; n.last_sy = s; n.primed = 1;
    if (c.primed && s != c.last_sy) begin
      t = (s == V_TOTAL - 1) ? 0 : s + 1;
      n.render = t;
      if (c.stage == M_DONE) n.sw = 1;
      else if (c.stage == M_PREP || c.stage == M_DRAW) begin
        n.ab = 1; n.ov = 1;
        if (c.count < 65535) n.count = c.count + 1;
      end
      n.ps = (t < V_RES);
      n.stage = (t < V_RES) ? M_PREP : M_IDLE;
      n.entry = c.cyc;
    end else if (c.stage == M_PREP && pd) begin
      n.ds = 1; n.stage = M_DRAW; n.entry = c.cyc;
    end else if (c.stage == M_DRAW && dd) begin
      n.stage = M_DONE;
    end
`ifdef LINE_SCHED_WATCHDOG_EN
    else if ((c.stage == M_PREP || c.stage == M_DRAW) && (c.cyc - c.entry) >= WATCHDOG_CYCLES) begin
      n.ab = 1; n.ov = 1; n.stage = M_IDLE;
      if (c.count < 65535) n.count = c.count + 1;
    end
`endif
    return n;
  endfunction

  always @(posedge clk_pix or negedge btn_rst) begin
    if (!btn_rst) m <= model_reset();
    else          m <= step(m, int'(sy), prep_done, draw_done);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_pix) begin
    chk("m_prep_start", 32'(prep_start), 32'(m.ps));
    chk("m_draw_start", 32'(draw_start), 32'(m.ds));
    chk("m_stage_abort", 32'(stage_abort), 32'(m.ab));
    chk("m_buffer_swap", 32'(buffer_swap), 32'(m.sw));
    chk("m_overrun", 32'(overrun), 32'(m.ov));
    chk("m_render_line", 32'(render_line), 32'(m.render));
    chk("m_overrun_count", 32'(overrun_count), 32'(m.count));
    chk("m_busy", 32'(busy), 32'(m.stage == M_PREP || m.stage == M_DRAW));
    chk("m_oam", 32'(oam_read_addr), (m.stage == M_PREP) ? 32'(oam_addr_prep) :
                                     (m.stage == M_DRAW) ? 32'(oam_addr_draw) : 32'd0);
  end

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic pulse_prep();
    prep_done = 1; tick(); prep_done = 0;
  endtask

  task automatic pulse_draw();
    draw_done = 1; tick(); draw_done = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    btn_rst = 0; sy = 10'd37; prep_done = 0; draw_done = 0;
    oam_addr_prep = 6'd5; oam_addr_draw = 6'd9;
    repeat (3) tick();
    chk("rst_render_line", 32'(render_line), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    btn_rst = 1;

    // 1: no spurious start after release, then one-cycle-late start on the sy change
    repeat (5) begin
      tick();
      chk("hold_no_prep_start", 32'(prep_start), 32'd0);
    end
    sy = 10'd38; tick();
    chk("t1_prep_start", 32'(prep_start), 32'd1);
    chk("t1_render_line", 32'(render_line), 32'd39);
    chk("t5_oam_prep", 32'(oam_read_addr), 32'd5);

    // 2: normal line
    repeat (19) tick();
    pulse_prep();
    chk("t2_draw_start", 32'(draw_start), 32'd1);
    chk("t5_oam_draw", 32'(oam_read_addr), 32'd9);
    repeat (299) tick();
    pulse_draw();
    chk("t5_oam_done", 32'(oam_read_addr), 32'd0);
    chk("t2_done_not_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    sy = 10'd39; tick();
    chk("t2_swap", 32'(buffer_swap), 32'd1);
    chk("t2_prep_start", 32'(prep_start), 32'd1);
    chk("t2_count", 32'(overrun_count), 32'd0);

    // 3: overrun in DRAW
    repeat (5) tick();
    pulse_prep();
    repeat (10) tick();
    sy = 10'd40; tick();
    chk("t3_abort", 32'(stage_abort), 32'd1);
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_no_swap", 32'(buffer_swap), 32'd0);
    chk("t3_count", 32'(overrun_count), 32'd1);
    chk("t3_prep_start", 32'(prep_start), 32'd1);

    // edge coincident with prep_done: edge wins, counted as overrun
    repeat (3) tick();
    prep_done = 1; sy = 10'd41; tick(); prep_done = 0;
    chk("prec_count", 32'(overrun_count), 32'd2);
    chk("prec_no_draw_start", 32'(draw_start), 32'd0);
    // draw_done while in PREP is ignored
    pulse_draw();
    chk("ign_still_prep_oam", 32'(oam_read_addr), 32'd5);

    // 4: end of visible area and frame wrap
    pulse_prep(); pulse_draw();
    sy = 10'd478; tick();
    chk("t4_swap_478", 32'(buffer_swap), 32'd1);
    chk("t4_render_479", 32'(render_line), 32'd479);
    pulse_prep(); pulse_draw();
    sy = 10'd479; tick();
    chk("t4_swap_479", 32'(buffer_swap), 32'd1);
    chk("t4_no_prep_479", 32'(prep_start), 32'd0);
    repeat (2) tick();
    sy = 10'd480; tick();
    chk("t4_render_481", 32'(render_line), 32'd481);
    chk("t4_no_prep_480", 32'(prep_start), 32'd0);
    sy = 10'd524; tick();
    chk("t4_render_0", 32'(render_line), 32'd0);
    pulse_prep(); pulse_draw();
    sy = 10'd0; tick();
    chk("t4_render_1", 32'(render_line), 32'd1);
    chk("t4_prep_wrap", 32'(prep_start), 32'd1);
    chk("t4_swap_wrap", 32'(buffer_swap), 32'd1);

    // 6: asynchronous reset while in DRAW
    pulse_prep();
    #3; btn_rst = 0; #2;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_oam", 32'(oam_read_addr), 32'd0);
    chk("t6_count", 32'(overrun_count), 32'd0);
    chk("t6_render", 32'(render_line), 32'd0);
    tick(); tick();
    btn_rst = 1;
    repeat (3) begin
      tick();
      chk("t6_no_abort", 32'(stage_abort), 32'd0);
    end

`ifdef LINE_SCHED_WATCHDOG_EN
    sy = 10'd1; tick();
    chk("wd_prep_start", 32'(prep_start), 32'd1);
    repeat (WATCHDOG_CYCLES - 1) tick();
    chk("wd_not_yet", 32'(stage_abort), 32'd0);
    tick();
    chk("wd_abort", 32'(stage_abort), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_count", 32'(overrun_count), 32'd1);
    sy = 10'd2; tick();
    chk("wd_no_swap", 32'(buffer_swap), 32'd0);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
